// File: rtl/tank_pkg.sv
// Shared tank definitions: fire-control state encoding, default slot count and
// fire key, and a priority encoder used to pick a free bullet slot.
package tank_pkg;

  localparam int unsigned DEFAULT_N_BULLETS = 5;
  localparam logic [7:0]  DEFAULT_FIRE_KEY  = 8'h2C;

  // Widest slot vector lowest_set() can encode.
  localparam int unsigned MAX_SLOTS = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    COOLDOWN
  } fire_state_t;

  // Index of the lowest set bit; 0 when nothing is set (callers test |v first).
  function automatic logic [4:0] lowest_set(input logic [MAX_SLOTS-1:0] v);
    lowest_set = '0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/bullet_fire_ctrl_if.sv
// Bus between the fire controller and the per-tank bullet instances.
//   create         controller -> bullets  one-hot create pulse
//   bullet_active  bullets -> controller  is_bullet_active from each slot
interface bullet_fire_ctrl_if
  import tank_pkg::*;
#(
  parameter int unsigned N_BULLETS = DEFAULT_N_BULLETS
);

  logic [N_BULLETS-1:0] create;
  logic [N_BULLETS-1:0] bullet_active;

  modport master (output create, input  bullet_active);
  modport slave  (input  create, output bullet_active);

endinterface

// File: rtl/key_edge_detect.sv
// Detects a new press of one key in the packed four-byte HID keycode word.
// Shared by the fire, turret and move key paths.
//   frame_clk   in  frame clock
//   Reset       in  synchronous active-low reset
//   keycode     in  four packed HID keycodes [31:24]..[7:0]
//   press_edge  out key present now and absent in the previous frame
module key_edge_detect #(
  parameter logic [7:0] KEY = 8'h00  // 0 disables the key entirely
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycode,
  output logic        press_edge
);

  logic key_hit;
  logic key_prev;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    key_hit = 1'b0;
    if (KEY != 8'h00) begin
      for (int i = 0; i < 4; i++) begin
        if (keycode[8*i +: 8] == KEY) key_hit = 1'b1;
      end
    end
  end

  // key_prev resets high so a key held through reset is not seen as a press.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge frame_clk) begin
    if (!Reset) key_prev <= 1'b1;
    else        key_prev <= key_hit;
  end

  assign press_edge = key_hit & ~key_prev;

endmodule

// File: rtl/bullet_fire_ctrl.sv
// Fire-control stage upstream of the per-tank bullet instances. Turns a fire
// key press into a one-cycle create pulse to the lowest free bullet slot,
// waits for that slot to go active, then holds off for a refire cooldown.
//   frame_clk    in   frame clock
//   Reset        in   synchronous active-low reset
//   enable       in   tank alive / game running; low inhibits firing
//   keycode      in   four packed HID keycodes
//   bus          master side: create out, bullet_active in
//   slot_sel     out  slot of the most recent shot
//   fire_busy    out  high whenever the controller is not idle
//   shots_fired  out  shot counter, wraps 255 -> 0
//   ack_err      out  sticky: a slot failed to go active in time
module bullet_fire_ctrl
  import tank_pkg::*;
#(
  parameter int unsigned N_BULLETS   = DEFAULT_N_BULLETS,
  parameter logic [7:0]  FIRE_KEY    = DEFAULT_FIRE_KEY,
  parameter int unsigned COOLDOWN    = 15,
  parameter int unsigned ACK_TIMEOUT = 4,
  localparam int unsigned SLOT_W = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               enable,
  input  logic [31:0]        keycode,
  bullet_fire_ctrl_if.master bus,
  output logic [SLOT_W-1:0]  slot_sel,
  output logic               fire_busy,
  output logic [7:0]         shots_fired,
  output logic               ack_err
);

  localparam int unsigned ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

  // The COOLDOWN parameter shadows the imported state literal, so the state
  // is always written as tank_pkg::COOLDOWN below.
  fire_state_t state_q, state_d;

  logic [N_BULLETS-1:0] create_q, create_d;
  logic [SLOT_W-1:0]    slot_d;
  logic [7:0]           shots_d;
  logic                 ack_err_d;
  logic [ACK_W-1:0]     ack_cnt_q, ack_cnt_d;
  logic [CD_W-1:0]      cd_cnt_q, cd_cnt_d;

  logic                 press_edge;
  logic [N_BULLETS-1:0] free;
  logic [SLOT_W-1:0]    sel;

  key_edge_detect #(.KEY(FIRE_KEY)) u_fire_key (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .press_edge (press_edge)
  );

  // A slot dropping active in the same cycle as the press already counts as free.
  assign free = ~bus.bullet_active;
  assign sel  = SLOT_W'(lowest_set(MAX_SLOTS'(free)));

  always_comb begin
    state_d   = state_q;
    create_d  = '0;
    slot_d    = slot_sel;
    shots_d   = shots_fired;
    ack_err_d = ack_err;
    ack_cnt_d = ack_cnt_q;
    cd_cnt_d  = cd_cnt_q;

    unique case (state_q)
      IDLE: begin
        // Presses that cannot be served here are dropped, never queued.
        if (press_edge && enable && (|free)) begin
          state_d       = ISSUE;
          slot_d        = sel;
          shots_d       = shots_fired + 8'd1;
          create_d[sel] = 1'b1;
        end
      end
      ISSUE: begin
        state_d   = WAIT_ACK;
        ack_cnt_d = '0;
      end
      WAIT_ACK: begin
        if (bus.bullet_active[slot_sel] || (ack_cnt_q == ACK_LAST)) begin
          if (!bus.bullet_active[slot_sel]) ack_err_d = 1'b1;
          if (COOLDOWN == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = tank_pkg::COOLDOWN;
            cd_cnt_d = CD_LOAD;
          end
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      tank_pkg::COOLDOWN: begin
        if (cd_cnt_q == '0) state_d = IDLE;
        else                cd_cnt_d = cd_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A create already registered still finishes its single cycle.
    if (!enable) begin
      state_d   = IDLE;
      ack_cnt_d = '0;
      cd_cnt_d  = '0;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      create_q    <= '0;
      slot_sel    <= '0;
      fire_busy   <= 1'b0;
      shots_fired <= '0;
      ack_err     <= 1'b0;
      ack_cnt_q   <= '0;
      cd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      create_q    <= create_d;
      slot_sel    <= slot_d;
      fire_busy   <= (state_d != IDLE);
      shots_fired <= shots_d;
      ack_err     <= ack_err_d;
      ack_cnt_q   <= ack_cnt_d;
      cd_cnt_q    <= cd_cnt_d;
    end
  end

  assign bus.create = create_q;

endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// Directed bench for bullet_fire_ctrl with default parameters, plus a second
// instance with FIRE_KEY = 0 that shares the key/enable/reset stimulus.
module tb_bullet_fire_ctrl;
  import tank_pkg::*;

  logic        frame_clk;
  logic        Reset;
  logic        enable;
  logic [31:0] keycode;

  logic [2:0]  slot_sel,  z_slot_sel;
  logic        fire_busy, z_fire_busy;
  logic [7:0]  shots_fired, z_shots_fired;
  logic        ack_err,   z_ack_err;

  int vectors     = 0;
  int miscompares = 0;
  int n_create    = 0;
  int z_creates   = 0;

  bullet_fire_ctrl_if #(.N_BULLETS(5)) bus ();
  bullet_fire_ctrl_if #(.N_BULLETS(5)) zbus ();

  bullet_fire_ctrl u_dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .enable      (enable),
    .keycode     (keycode),
    .bus         (bus),
    .slot_sel    (slot_sel),
    .fire_busy   (fire_busy),
    .shots_fired (shots_fired),
    .ack_err     (ack_err)
  );

  bullet_fire_ctrl #(.FIRE_KEY(8'h00)) u_dut_nokey (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .enable      (enable),
    .keycode     (keycode),
    .bus         (zbus),
    .slot_sel    (z_slot_sel),
    .fire_busy   (z_fire_busy),
    .shots_fired (z_shots_fired),
    .ack_err     (z_ack_err)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one frame; everything is then sampled and driven 1 time unit later.
  task automatic tick();
    @(posedge frame_clk);
    #1;
    if (zbus.create !== 5'b0) z_creates++;
  endtask

  initial begin
    Reset              = 1'b0;
    enable             = 1'b1;
    keycode            = 32'h0;
    bus.bullet_active  = 5'b0;
    zbus.bullet_active = 5'b0;

    // ---- 1: reset state, held key fires exactly once ----
    repeat (3) tick();
    chk("rst_create", bus.create, 5'b00000);
    chk("rst_slot",   slot_sel, 0);
    chk("rst_busy",   fire_busy, 0);
    chk("rst_shots",  shots_fired, 0);
    chk("rst_ackerr", ack_err, 0);

    Reset = 1'b1;
    tick();                          // key_prev leaves its reset value
    keycode = 32'h0000_002C;         // press in cycle t
    n_create = 0;
    for (int i = 0; i < 50; i++) begin
      tick();                        // now in cycle t+1+i
      if (i == 0) chk("t1_create_lat", bus.create, 5'b00001);
      if (bus.create !== 5'b0) n_create++;
      if (i == 2) bus.bullet_active = 5'b00001;  // slot goes active 2 frames after create
    end
    chk("t1_one_create", n_create, 1);
    chk("t1_shots",      shots_fired, 1);
    chk("t1_idle",       fire_busy, 0);
    chk("t1_no_ackerr",  ack_err, 0);
    keycode = 32'h0;
    bus.bullet_active = 5'b0;
    tick();

    // ---- 2: lowest free slot, then all slots busy ----
    bus.bullet_active = 5'b00111;
    keycode = 32'h2C00_0000;
    tick();
    chk("t2_create", bus.create, 5'b01000);
    chk("t2_slot",   slot_sel, 3);
    chk("t2_shots",  shots_fired, 2);
    keycode = 32'h0;
    bus.bullet_active = 5'b01111;
    repeat (20) tick();
    chk("t2_idle", fire_busy, 0);
    bus.bullet_active = 5'b11111;
    keycode = 32'h0000_2C00;
    tick();
    chk("t2_full_create", bus.create, 5'b00000);
    chk("t2_full_busy",   fire_busy, 0);
    chk("t2_full_shots",  shots_fired, 2);
    keycode = 32'h0;
    bus.bullet_active = 5'b0;
    tick();

    // ---- 3: press during cooldown dropped, press at +20 fires ----
    keycode = 32'h0000_002C;         // cycle p
    tick();                          // p+1
    chk("t3_first", bus.create, 5'b00001);
    chk("t3_shots1", shots_fired, 3);
    keycode = 32'h0;
    bus.bullet_active = 5'b00001;
    repeat (4) tick();               // p+5
    keycode = 32'h0000_002C;
    tick();                          // p+6
    chk("t3_drop_create", bus.create, 5'b00000);
    chk("t3_drop_shots",  shots_fired, 3);
    chk("t3_drop_busy",   fire_busy, 1);
    keycode = 32'h0;
    bus.bullet_active = 5'b0;
    repeat (14) tick();              // p+20
    keycode = 32'h0000_002C;
    tick();                          // p+21
    chk("t3_refire", bus.create, 5'b00001);
    chk("t3_shots2", shots_fired, 4);
    keycode = 32'h0;
    bus.bullet_active = 5'b00001;
    repeat (17) tick();              // p+38: cooldown p+23..p+37
    chk("t3_back_idle", fire_busy, 0);
    bus.bullet_active = 5'b0;

    // ---- 4: slot never acks ----
    keycode = 32'h0000_002C;         // cycle q
    tick();                          // q+1 ISSUE
    chk("t4_create", bus.create, 5'b00001);
    chk("t4_shots",  shots_fired, 5);
    keycode = 32'h0;
    repeat (4) tick();               // q+5: last WAIT_ACK cycle
    chk("t4_ackerr_pre", ack_err, 0);
    tick();                          // q+6
    chk("t4_ackerr",  ack_err, 1);
    chk("t4_cd_busy", fire_busy, 1);
    repeat (14) tick();              // q+20: last cooldown cycle
    chk("t4_cd_end_busy", fire_busy, 1);
    tick();                          // q+21
    chk("t4_idle",        fire_busy, 0);
    chk("t4_ackerr_hold", ack_err, 1);

    // ---- 5: enable dropped during cooldown ----
    keycode = 32'h0000_002C;         // cycle r
    tick();
    chk("t5_create", bus.create, 5'b00001);
    chk("t5_shots",  shots_fired, 6);
    keycode = 32'h0;
    bus.bullet_active = 5'b00001;
    repeat (4) tick();               // r+5, in cooldown
    chk("t5_cd_busy", fire_busy, 1);
    enable = 1'b0;
    tick();
    chk("t5_dis_busy", fire_busy, 0);
    keycode = 32'h0000_002C;
    tick();
    chk("t5_dis_create", bus.create, 5'b00000);
    chk("t5_dis_shots",  shots_fired, 6);
    chk("t5_ackerr_sticky", ack_err, 1);
    keycode = 32'h0;
    enable = 1'b1;
    bus.bullet_active = 5'b0;
    tick();
    keycode = 32'h0000_002C;
    tick();
    chk("t5_reen_create", bus.create, 5'b00001);
    chk("t5_reen_shots",  shots_fired, 7);
    keycode = 32'h0;
    bus.bullet_active = 5'b00001;
    repeat (20) tick();
    bus.bullet_active = 5'b0;
    chk("nokey_shots", z_shots_fired, 0);
    chk("nokey_busy",  z_fire_busy, 0);

    // ---- 6: key held across reset ----
    keycode = 32'h002C_0000;
    Reset = 1'b0;
    repeat (2) tick();
    chk("t6_rst_shots",  shots_fired, 0);
    chk("t6_rst_ackerr", ack_err, 0);
    Reset = 1'b1;
    n_create = 0;
    repeat (5) begin
      tick();
      if (bus.create !== 5'b0) n_create++;
    end
    chk("t6_held_nofire", n_create, 0);
    chk("t6_held_busy",   fire_busy, 0);
    keycode = 32'h0;
    tick();
    keycode = 32'h002C_0000;
    tick();
    chk("t6_repress_create", bus.create, 5'b00001);
    chk("t6_repress_shots",  shots_fired, 1);
    keycode = 32'h0;
    repeat (3) tick();
    chk("nokey_creates", z_creates, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
